// File: rtl/qam16_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : qam16_rx_deframer
//  Description : Receive frame controller behind the QAM16 demapper. Hunts
//                for a 4-symbol sync word, then packs the following payload
//                symbols (high nibble first) into bytes presented on a
//                valid/ready output holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam16_rx_deframer #(
  parameter logic [15:0] SYNC_WORD     = 16'hA5C3,
  parameter int          PAYLOAD_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [3:0] sym_data,
  input  logic       rx_abort,
  output logic [7:0] byte_data,
  output logic       byte_last,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       sync_lock,
  output logic       overrun
);

  // Byte index that carries the end-of-frame tag.
  localparam logic [7:0] LAST_BCNT = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sh_q, sh_d;
  logic [2:0]  fill_q, fill_d;
  logic        phase_q, phase_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        fs_q, fs_d;
  logic        ovr_q, ovr_d;

  // Scratch values of the combinational process.
  logic [15:0] sh_shift;
  logic [2:0]  fill_inc;
  logic        accept;
  logic        cpl;
  logic [7:0]  cpl_byte;
  logic        cpl_last;

  // State and datapath registers; reset drops everything including a pending byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      sh_q    <= 16'h0000;
      fill_q  <= 3'd0;
      phase_q <= 1'b0;
      hi_q    <= 4'h0;
      bcnt_q  <= 8'd0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: sync hunt, nibble packing, and output holding register control.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    fill_d   = fill_q;
    phase_d  = phase_q;
    hi_d     = hi_q;
    bcnt_d   = bcnt_q;
    data_d   = data_q;
    last_d   = last_q;
    valid_d  = valid_q;
    fs_d     = 1'b0;
    ovr_d    = 1'b0;
    cpl      = 1'b0;
    cpl_byte = 8'h00;
    cpl_last = 1'b0;
    sh_shift = {sh_q[11:0], sym_data};
    fill_inc = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    accept   = valid_q & byte_ready;

    if (rx_abort) begin
      // Abort outranks any symbol this cycle, including one that would match.
      state_d = HUNT;
      sh_d    = 16'h0000;
      fill_d  = 3'd0;
      phase_d = 1'b0;
      bcnt_d  = 8'd0;
    end else if (sym_valid) begin
      case (state_q)
        HUNT: begin
          // Sliding window: a mismatch never flushes the shift register.
          sh_d   = sh_shift;
          fill_d = fill_inc;
          if ((sh_shift == SYNC_WORD) && (fill_inc == 3'd4)) begin
            state_d = PAYLOAD;
            fs_d    = 1'b1;
            phase_d = 1'b0;
            bcnt_d  = 8'd0;
          end
        end
        PAYLOAD: begin
          if (!phase_q) begin
            hi_d    = sym_data;
            phase_d = 1'b1;
          end else begin
            cpl      = 1'b1;
            cpl_byte = {hi_q, sym_data};
            cpl_last = (bcnt_q == LAST_BCNT);
            phase_d  = 1'b0;
            bcnt_d   = bcnt_q + 8'd1;
            if (cpl_last) begin
              state_d = HUNT;
              sh_d    = 16'h0000;
              fill_d  = 3'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // A completed byte loads only if the holding register is free this cycle;
    // otherwise it is dropped, but the byte counter above still advanced.
    if (cpl) begin
      if (!valid_q || accept) begin
        data_d  = cpl_byte;
        last_d  = cpl_last;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign byte_data   = data_q;
  assign byte_last   = last_q;
  assign byte_valid  = valid_q;
  assign frame_start = fs_q;
  assign sync_lock   = (state_q == PAYLOAD);
  assign overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_qam16_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qam16_rx_deframer
//  Description : Self-checking bench for qam16_rx_deframer with a queue-based
//                behavioural model, directed scenarios and random frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qam16_rx_deframer;

  localparam int          PB   = 2;
  localparam logic [15:0] SYNC = 16'hA5C3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [3:0] sym_data = 4'h0;
  logic       rx_abort = 1'b0;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       frame_start;
  logic       sync_lock;
  logic       overrun;

  qam16_rx_deframer #(.SYNC_WORD(SYNC), .PAYLOAD_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data),
    .rx_abort(rx_abort), .byte_data(byte_data), .byte_last(byte_last),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .frame_start(frame_start),
    .sync_lock(sync_lock), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_locked;
  int         m_hist[$];
  int         m_nib, m_hi, m_bytes;
  bit         e_valid, e_last, e_fs, e_ovr;
  logic [7:0] e_data;
  int         n_sampled = 0;
  bit         acc, nb, nl;
  logic [7:0] nd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 0; m_hist.delete(); m_nib = 0; m_hi = 0; m_bytes = 0;
      e_valid = 0; e_last = 0; e_fs = 0; e_ovr = 0; e_data = 8'h00;
    end else begin
      acc = e_valid && byte_ready;
      nb = 0; nl = 0; nd = 8'h00; e_fs = 0; e_ovr = 0;
      if (sym_valid) n_sampled++;
      if (rx_abort) begin
        m_locked = 0; m_hist.delete(); m_nib = 0; m_bytes = 0;
      end else if (sym_valid) begin
        if (!m_locked) begin
          m_hist.push_back(int'(sym_data));
          if (m_hist.size() > 4) void'(m_hist.pop_front());
          if (m_hist.size() == 4 &&
              (m_hist[0] * 4096 + m_hist[1] * 256 + m_hist[2] * 16 + m_hist[3]) == int'(SYNC)) begin
            m_locked = 1; e_fs = 1; m_nib = 0; m_bytes = 0; m_hist.delete();
          end
        end else begin
          if (m_nib % 2 == 0) m_hi = int'(sym_data);
          else begin
            nb = 1;
            nd = 8'(m_hi * 16 + int'(sym_data));
            nl = (m_bytes == PB - 1);
            m_bytes++;
            if (nl) begin m_locked = 0; m_hist.delete(); end
          end
          m_nib++;
        end
      end
      if (nb) begin
        if (!e_valid || acc) begin e_valid = 1; e_data = nd; e_last = nl; end
        else e_ovr = 1;
      end else if (acc) e_valid = 0;
    end
  end

  // ---------------- per-cycle compare and observation ----------------
  logic [8:0] got[$];
  int fs_cnt, ov_cnt, fs_at, base;

  always @(negedge clk) begin
    chk("byte_valid", 32'(byte_valid), 32'(e_valid));
    chk("sync_lock", 32'(sync_lock), 32'(m_locked));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    if (e_valid) begin
      chk("byte_data", 32'(byte_data), 32'(e_data));
      chk("byte_last", 32'(byte_last), 32'(e_last));
    end
    if (!rst && byte_valid && byte_ready) got.push_back({byte_last, byte_data});
    if (frame_start) begin fs_cnt++; fs_at = n_sampled - base; end
    if (overrun) ov_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  bit rnd_ready = 0;

  task automatic set_ready();
    if (rnd_ready) byte_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_sym(input logic [3:0] s);
    @(posedge clk); #1;
    sym_valid = 1'b1; sym_data = s; rx_abort = 1'b0; set_ready();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sym_valid = 1'b0; rx_abort = 1'b0; set_ready();
    end
  endtask

  task automatic send_sync();
    send_sym(SYNC[15:12]); send_sym(SYNC[11:8]); send_sym(SYNC[7:4]); send_sym(SYNC[3:0]);
  endtask

  task automatic clr();
    got.delete(); fs_cnt = 0; ov_cnt = 0; fs_at = -1; base = n_sampled;
  endtask

  function automatic logic [8:0] g(input int i);
    return (got.size() > i) ? got[i] : 9'h1FF;
  endfunction

  initial begin
    clr();
    // Reset state
    #2;
    chk("rst_valid", 32'(byte_valid), 0); chk("rst_lock", 32'(sync_lock), 0);
    chk("rst_data", 32'(byte_data), 0);   chk("rst_fs", 32'(frame_start), 0);
    idle(2);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // 1: basic frame
    clr();
    send_sync(); send_sym(4'h1); send_sym(4'h2); send_sym(4'h3); send_sym(4'h4);
    idle(4);
    chk("t1_count", got.size(), 2);
    chk("t1_b0", 32'(g(0)), 32'h012);
    chk("t1_b1", 32'(g(1)), 32'h134);
    chk("t1_fs", fs_cnt, 1);
    chk("t1_lock_end", 32'(sync_lock), 0);

    // 2: overlapping sync prefix
    clr();
    send_sym(4'h3); send_sym(4'hA); send_sym(4'h5); send_sym(4'hA);
    send_sym(4'h5); send_sym(4'hC); send_sym(4'h3);
    send_sym(4'h5); send_sym(4'h6); send_sym(4'h7); send_sym(4'h8);
    idle(4);
    chk("t2_fs", fs_cnt, 1);
    chk("t2_fs_at", fs_at, 7);
    chk("t2_b0", 32'(g(0)), 32'h056);
    chk("t2_b1", 32'(g(1)), 32'h178);

    // 3: backpressure drops the second byte, frame still ends
    clr();
    byte_ready = 1'b0;
    send_sync(); send_sym(4'h1); send_sym(4'h2); send_sym(4'h3); send_sym(4'h4);
    idle(3);
    chk("t3_held", 32'(byte_valid), 1);
    byte_ready = 1'b1;
    idle(3);
    chk("t3_ovr", ov_cnt, 1);
    chk("t3_count", got.size(), 1);
    chk("t3_b0", 32'(g(0)), 32'h012);
    send_sync(); send_sym(4'h9); send_sym(4'hA); send_sym(4'hB); send_sym(4'hC);
    idle(4);
    chk("t3_next", 32'(g(1)), 32'h09A);
    chk("t3_next_last", 32'(g(2)), 32'h1BC);

    // 4: random gaps between payload symbols
    clr();
    send_sync();
    for (int i = 1; i <= 4; i++) begin
      idle($urandom_range(0, 5));
      send_sym(4'(i));
    end
    idle(4);
    chk("t4_b0", 32'(g(0)), 32'h012);
    chk("t4_b1", 32'(g(1)), 32'h134);

    // 5a: abort coinciding with a match suppresses frame_start
    clr();
    send_sym(4'hA); send_sym(4'h5); send_sym(4'hC);
    @(posedge clk); #1 sym_valid = 1'b1; sym_data = 4'h3; rx_abort = 1'b1;
    idle(3);
    chk("t5_abort_match_fs", fs_cnt, 0);
    // 5b: abort mid-payload, then a fresh frame
    clr();
    send_sync(); send_sym(4'h1); send_sym(4'h2); send_sym(4'h3);
    @(posedge clk); #1 sym_valid = 1'b1; sym_data = 4'h4; rx_abort = 1'b1;
    idle(1);
    chk("t5_lock_drop", 32'(sync_lock), 0);
    send_sync(); send_sym(4'hD); send_sym(4'hE); send_sym(4'hF); send_sym(4'h0);
    idle(4);
    chk("t5_b0", 32'(g(0)), 32'h012);
    chk("t5_b1", 32'(g(1)), 32'h0DE);
    chk("t5_b2", 32'(g(2)), 32'h1F0);

    // 6: asynchronous reset mid-frame with a pending byte
    byte_ready = 1'b0;
    send_sync(); send_sym(4'h1); send_sym(4'h2); send_sym(4'h3);
    idle(1);
    @(posedge clk); #3 rst = 1'b1; sym_valid = 1'b0;
    #1;
    chk("t6_valid", 32'(byte_valid), 0); chk("t6_lock", 32'(sync_lock), 0);
    chk("t6_data", 32'(byte_data), 0);   chk("t6_last", 32'(byte_last), 0);
    chk("t6_fs", 32'(frame_start), 0);   chk("t6_ovr", 32'(overrun), 0);
    idle(2);
    @(posedge clk); #1 rst = 1'b0; byte_ready = 1'b1;
    clr();
    send_sync(); send_sym(4'h4); send_sym(4'h5); send_sym(4'h6); send_sym(4'h7);
    idle(4);
    chk("t6_fs_after", fs_cnt, 1);
    chk("t6_b0", 32'(g(0)), 32'h045);
    chk("t6_b1", 32'(g(1)), 32'h167);

    // Random frames with noise, gaps, random ready and occasional aborts
    rnd_ready = 1;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) send_sym(4'($urandom_range(0, 15)));
      send_sync();
      for (int k = 0; k < 2 * PB; k++) begin
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 39) == 0) begin
          @(posedge clk); #1 rx_abort = 1'b1; sym_valid = 1'($urandom_range(0, 1));
        end else send_sym(4'($urandom_range(0, 15)));
      end
      idle($urandom_range(0, 3));
    end
    rnd_ready = 0; byte_ready = 1'b1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
